// File: rtl/led_pkg.sv
// Shared constants, brightness type and saturating subtract for the LED PWM fader.
package led_pkg;

    localparam int unsigned DEF_N_LED      = 14;
    localparam int unsigned DEF_PWM_BITS   = 8;
    localparam int unsigned DEF_DECAY_DIV  = 65536;
    localparam int unsigned DEF_DECAY_STEP = 16;

    typedef logic [DEF_PWM_BITS-1:0] bright_t;

    // a - b, clamped at 0; the extra top bit of the difference is the borrow
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[32] ? 32'd0 : d[31:0];
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: brightness register with decay, optional gamma, PWM compare and drive flop.
// Build option: LED_PWM_FADER_GAMMA_EN squares brightness into the duty value.
module led_pwm_chan
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS   = DEF_PWM_BITS,
    parameter int unsigned DECAY_STEP = DEF_DECAY_STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_pattern,
    input  logic [PWM_BITS-1:0] i_level,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_tick,
    output logic                o_led_n
);

    logic [PWM_BITS-1:0] r_bright;
    logic                r_led_n;
    logic [PWM_BITS-1:0] w_dec;
    logic [PWM_BITS-1:0] w_duty;

    assign w_dec = PWM_BITS'(sat_sub(32'(r_bright), 32'(DECAY_STEP)));

`ifdef LED_PWM_FADER_GAMMA_EN
    localparam int unsigned SQ_W = 2 * PWM_BITS;
    logic [SQ_W-1:0] w_sq;

    // Squared response, kept combinational so every channel has the same latency
    assign w_sq   = SQ_W'(r_bright) * SQ_W'(r_bright);
    assign w_duty = PWM_BITS'(w_sq >> PWM_BITS);
`else
    assign w_duty = r_bright;
`endif

    // A lit request overrides a coincident decay tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bright <= '0;
            r_led_n  <= 1'b1;
        end else begin
            if (i_pattern) begin
                r_bright <= i_level;
            end else if (i_tick) begin
                r_bright <= w_dec;
            end
            r_led_n <= ~(w_duty > i_pwm_cnt);
        end
    end

    assign o_led_n = r_led_n;

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader top: shared PWM counter, decay prescaler and frame pulse feeding N_LED channels.
// Build option: LED_PWM_FADER_GAMMA_EN (gamma-corrected duty in each channel).
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int unsigned N_LED      = DEF_N_LED,
    parameter int unsigned PWM_BITS   = DEF_PWM_BITS,
    parameter int unsigned DECAY_DIV  = DEF_DECAY_DIV,
    parameter int unsigned DECAY_STEP = DEF_DECAY_STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LED-1:0]    pattern,
    input  logic [PWM_BITS-1:0] level,
    output logic [N_LED-1:0]    led_n,
    output logic                frame
);

    localparam int unsigned     PRE_W   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PRE_W-1:0]    r_pre;
    logic                r_frame;
    logic                w_tick;

    assign w_tick = (r_pre == PRE_MAX);

    // Free-running PWM counter, decay prescaler and wrap pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_pre     <= '0;
            r_frame   <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            r_pre     <= w_tick ? '0 : r_pre + PRE_W'(1);
            r_frame   <= (r_pwm_cnt == '1);
        end
    end

    assign frame = r_frame;

    for (genvar g = 0; g < int'(N_LED); g++) begin : g_chan
        led_pwm_chan #(
            .PWM_BITS   (PWM_BITS),
            .DECAY_STEP (DECAY_STEP)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_pattern  (pattern[g]),
            .i_level    (level),
            .i_pwm_cnt  (r_pwm_cnt),
            .i_tick     (w_tick),
            .o_led_n    (led_n[g])
        );
    end

endmodule
